alu: RTL and testbench



---
 rtl/alu.sv | 95 +++++++++
 tb/tb_alu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Purpose  : Registered WIDTH-bit ALU (add/sub/logic/shift) with zero and
//            carry flags, one-cycle latency, one operation per cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             out_valid
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_NOT = 3'b101;
    localparam logic [2:0] c_OP_SHL = 3'b110;
    localparam logic [2:0] c_OP_SHR = 3'b111;

    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_zero;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_out_valid;

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (op)
            c_OP_ADD: {w_carry, w_result} = {1'b0, a} + {1'b0, b};
            c_OP_SUB: begin
                w_result = a - b;
                w_carry  = (a < b);
            end
            c_OP_AND: w_result = a & b;
            c_OP_OR:  w_result = a | b;
            c_OP_XOR: w_result = a ^ b;
            c_OP_NOT: w_result = ~a;
            c_OP_SHL: begin
                w_result = {a[WIDTH-2:0], 1'b0};
                w_carry  = a[WIDTH-1];
            end
            c_OP_SHR: begin
                w_result = {1'b0, a[WIDTH-1:1]};
                w_carry  = a[0];
            end
            // Only reachable with X/Z op in simulation: clean zero result.
            default: begin
                w_result = '0;
                w_carry  = 1'b0;
            end
        endcase
        w_zero = (w_result == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_zero   <= w_zero;
                r_carry  <= w_carry;
            end
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module   : tb_alu
// Purpose  : Scoreboard bench for alu: directed cases plus random stimulus
//            checked against an integer-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu;

    localparam int W = 4;
    localparam int M = 1 << W;

    typedef struct {
        int res;
        int c;
        int z;
        int due;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         out_valid;

    exp_t q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   last_res;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model works on plain integers rather than bit slices.
    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int   t;
        e.c = 0;
        case (o)
            0: begin t = x + y; e.res = t % M; e.c = (t >= M); end
            1: begin t = x - y; e.res = (t + M) % M; e.c = (t < 0); end
            2: e.res = x & y;
            3: e.res = x | y;
            4: e.res = x ^ y;
            5: e.res = (M - 1) - x;
            6: begin e.res = (x * 2) % M; e.c = (x >= M / 2); end
            default: begin e.res = x / 2; e.c = x % 2; end
        endcase
        e.z   = (e.res == 0);
        e.due = 0;
        return e;
    endfunction

    task automatic issue(input int o, input int x, input int y);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        op       = 3'(o);
        a        = W'(x);
        b        = W'(y);
        e        = model(o, x, y);
        e.due    = cyc + 1;
        last_res = e.res;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        op       = 3'($urandom);
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("latency_cycle", cyc, e.due);
                check("result", int'(result), e.res);
                check("carry", int'(carry), e.c);
                check("zero", int'(zero), e.z);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_res = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 4'd5;
        b        = 4'd3;
        op       = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_result", int'(result), 0);
        check("reset_zero", int'(zero), 1);
        check("reset_carry", int'(carry), 0);
        check("reset_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;

        // Directed cases, issued back to back.
        issue(0, 5, 3);
        issue(0, 15, 1);
        issue(0, 0, 0);
        issue(1, 8, 3);
        issue(1, 3, 8);
        issue(2, 'b1010, 'b1100);
        issue(3, 'b1010, 'b1100);
        issue(4, 'b1010, 'b1100);
        issue(5, 'b1010, 'b1100);
        issue(6, 'b1010, 0);
        issue(7, 'b1010, 0);
        issue(6, 'b1000, 0);
        idle();
        idle();

        issue(0, 1, 1);
        issue(1, 2, 1);
        issue(4, 15, 15);
        idle();
        @(posedge clk);
        @(negedge clk);
        check("hold_out_valid", int'(out_valid), 0);
        check("hold_result", int'(result), last_res);
        check("hold_zero", int'(zero), 1);

        // Random stimulus with random gaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else issue(int'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)),
                       int'($urandom_range(0, M - 1)));
        end
        idle();
        @(posedge clk);
        @(negedge clk);
        check("final_hold_result", int'(result), last_res);
        check("final_out_valid", int'(out_valid), 0);

        // Mid-stream reset discards the in-flight op.
        issue(0, 7, 7);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b1;
        if (q.size() > 0) void'(q.pop_back());
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_result", int'(result), 0);
        issue(1, 9, 2);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
